mult_div_sequencer: RTL

Iterative multi-cycle multiply/divide unit that sits beside the single-cycle ALU in the EX stage. It accepts MIPS `mult`/`multu`/`div`/`divu` requests, then sequences a shift-add multiply or a restoring divide over WIDTH cycles on captured operands. It writes the HI/LO result registers and reports `busy` so the hazard logic can stall dependent instructions. HI/LO are read by the `mfhi`/`mflo` path.

---
 rtl/mult_div_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mult_div_sequencer.sv
// Iterative MIPS mult/multu/div/divu unit: shift-add multiply or restoring divide, HI/LO result registers.
// Latency: WIDTH iterations + 1 fix-up cycle; done pulses WIDTH+2 cycles after the accept cycle.
// Backpressure: none queued; start is taken only in IDLE/DONE, and busy stalls dependent instructions.
module mult_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_b_q, neg_b_d;
    logic               dz_q, dz_d;
    logic               is_div_q, is_div_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               accept;
    logic               op_signed;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   mul_addend;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Valid codes are 0110xx: bit 1 selects divide, bit 0 selects unsigned.
    assign accept    = start && (Funct[5:2] == 4'b0110);
    assign op_signed = ~Funct[0];
    assign a_neg     = op_signed & SrcA[WIDTH-1];
    assign b_neg     = op_signed & SrcB[WIDTH-1];
    assign a_mag     = a_neg ? -SrcA : SrcA;
    assign b_mag     = b_neg ? -SrcB : SrcB;

    assign mul_addend = acc_q[0] ? opnd_q : '0;
    assign mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    assign div_shift  = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_trial  = div_shift - {1'b0, opnd_q};

    // A zero divisor leaves remainder = |dividend|, so restoring its sign yields SrcA; only the quotient skips fix-up.
    assign prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    assign quo_fix  = ((neg_a_q ^ neg_b_q) && !dz_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        dz_d     = dz_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (accept) begin
                    cnt_d    = '0;
                    neg_a_d  = a_neg;
                    neg_b_d  = b_neg;
                    is_div_d = Funct[1];
                    dz_d     = Funct[1] && (SrcB == '0);
                    if (Funct[1]) begin
                        state_d = S_DIV;
                        acc_d   = {{WIDTH{1'b0}}, a_mag};
                        opnd_d  = b_mag;
                    end else begin
                        state_d = S_MUL;
                        acc_d   = {{WIDTH{1'b0}}, b_mag};
                        opnd_d  = a_mag;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = S_FIX;
                end
            end
            S_DIV: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    if (!div_trial[WIDTH])
                        acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else
                        acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_MUL) || (state_d == S_DIV) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            dz_q     <= 1'b0;
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            dz_q     <= dz_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
